versa_rst_seq: RTL and testbench



---
 rtl/versa_pkg.sv | 25 ++
 rtl/versa_dn_cnt.sv | 37 +++
 rtl/versa_rst_seq.sv | 154 +++++++++++++++
 tb/tb_versa_rst_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/versa_pkg.sv
// versa_pkg -- shared definitions for the VERSA reset sequencer.
//   state_e      : sequencer FSM encoding (IDLE=0, HOLD=1, GUARD=2, LOCKOUT=3)
//   CAUSE_*      : 2-bit violation cause codes reported by the VERSA monitor
//   CNT_W        : width of the hold/guard down-counters
//   RETRY_W      : width of the retry counter
//   LOG_W        : width of the violation log counter
package versa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    GUARD   = 2'd2,
    LOCKOUT = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_GPIO_RD    = 2'd0;
  localparam logic [1:0] CAUSE_META_ER_WR = 2'd1;
  localparam logic [1:0] CAUSE_ER_INVALID = 2'd2;
  localparam logic [1:0] CAUSE_ER_EXIT    = 2'd3;

  localparam int CNT_W   = 8;
  localparam int RETRY_W = 4;
  localparam int LOG_W   = 8;

endpackage

// File: rtl/versa_dn_cnt.sv
// versa_dn_cnt -- loadable down-counter with a zero flag.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero instead of wrapping
//   zero     : count is zero
module versa_dn_cnt
  import versa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/versa_rst_seq.sv
// versa_rst_seq -- turns the VERSA monitor's level reset request into
// fixed-width CPU reset pulses, retrying a bounded number of times before
// locking the CPU in reset permanently.
//   clk        : clock, rising edge
//   rst        : synchronous active-high power-on reset
//   viol_req   : level reset request from the VERSA monitor
//   viol_cause : cause code of the current violation (see versa_pkg)
//   puc_rst    : registered CPU reset
//   lockout    : registered permanent-reset indicator
//   busy       : sequencer is not IDLE
//   last_cause : cause latched at the most recent violation
//   viol_cnt   : saturating violation count
// Optional build macro VERSA_VIOL_LOG_EN enables last_cause/viol_cnt
// logging; without it both outputs are constant zero.
module versa_rst_seq
  import versa_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int GUARD_CYCLES = 8,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       viol_req,
  input  logic [1:0] viol_cause,
  output logic       puc_rst,
  output logic       lockout,
  output logic       busy,
  output logic [1:0] last_cause,
  output logic [7:0] viol_cnt
);

  localparam logic [CNT_W-1:0]   HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

  state_e               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 puc_rst_q, lockout_q;
  logic                 hold_load, hold_dec, hold_zero;
  logic                 guard_load, guard_dec, guard_zero;
  logic                 viol_start;

  versa_dn_cnt u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  versa_dn_cnt u_guard_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (guard_load),
    .load_val (GUARD_LOAD),
    .dec      (guard_dec),
    .zero     (guard_zero)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    guard_load = 1'b0;
    guard_dec  = 1'b0;
    viol_start = 1'b0;
    case (state_q)
      IDLE: begin
        retry_d = '0;
        if (viol_req) begin
          state_d    = HOLD;
          hold_load  = 1'b1;
          viol_start = 1'b1;
        end
      end
      HOLD: begin
        // The cycle the counter reads zero is the last cycle of the pulse.
        if (hold_zero) begin
          state_d    = GUARD;
          guard_load = 1'b1;
        end else begin
          hold_dec = 1'b1;
        end
      end
      GUARD: begin
        if (!viol_req) begin
          state_d = IDLE;
        end else if (guard_zero) begin
          if (retry_q != '1) retry_d = retry_q + RETRY_ONE;
          if (retry_d == RETRY_LIMIT) begin
            state_d = LOCKOUT;
          end else begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end
        end else begin
          guard_dec = 1'b1;
        end
      end
      LOCKOUT: state_d = LOCKOUT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      retry_q   <= '0;
      puc_rst_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      puc_rst_q <= (state_d == HOLD) || (state_d == LOCKOUT);
      lockout_q <= (state_d == LOCKOUT);
    end
  end

  assign puc_rst = puc_rst_q;
  assign lockout = lockout_q;
  assign busy    = (state_q != IDLE);

`ifdef VERSA_VIOL_LOG_EN
  logic [1:0]       last_cause_q;
  logic [LOG_W-1:0] viol_cnt_q;

  // Only a fresh violation out of IDLE is logged; retries are not.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_cause_q <= '0;
      viol_cnt_q   <= '0;
    end else if (viol_start) begin
      last_cause_q <= viol_cause;
      if (viol_cnt_q != '1) viol_cnt_q <= viol_cnt_q + LOG_W'(1);
    end
  end

  assign last_cause = last_cause_q;
  assign viol_cnt   = viol_cnt_q;
`else
  logic unused_log;
  assign unused_log = (^viol_cause) ^ viol_start;
  assign last_cause = '0;
  assign viol_cnt   = '0;
`endif

endmodule

// File: tb/tb_versa_rst_seq.sv
// tb_versa_rst_seq -- self-checking bench for versa_rst_seq with default
// parameters (HOLD=16, GUARD=8, MAX_RETRY=3). Log expectations follow
// VERSA_VIOL_LOG_EN: logged values when defined, zero otherwise.
module tb_versa_rst_seq;

`ifdef VERSA_VIOL_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       viol_req;
  logic [1:0] viol_cause;
  logic       puc_rst, lockout, busy;
  logic [1:0] last_cause;
  logic [7:0] viol_cnt;

  int checks   = 0;
  int failures = 0;

  // Bench-side log model.
  logic [7:0] exp_cnt = 8'd0;
  logic [1:0] exp_lc  = 2'd0;

  versa_rst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .viol_req   (viol_req),
    .viol_cause (viol_cause),
    .puc_rst    (puc_rst),
    .lockout    (lockout),
    .busy       (busy),
    .last_cause (last_cause),
    .viol_cnt   (viol_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_span(input int n, input logic p, input logic l,
                             input logic b, input string name);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s[%0d].puc_rst", name, k), 32'(puc_rst), 32'(p));
      check($sformatf("%s[%0d].lockout", name, k), 32'(lockout), 32'(l));
      check($sformatf("%s[%0d].busy", name, k), 32'(busy), 32'(b));
    end
  endtask

  task automatic model_start(input logic [1:0] cause);
    exp_lc  = cause;
    exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
  endtask

  task automatic model_reset();
    exp_lc  = 2'd0;
    exp_cnt = 8'd0;
  endtask

  task automatic check_log(input string name);
    check({name, ".last_cause"}, 32'(last_cause), LOG_EN ? 32'(exp_lc) : 32'd0);
    check({name, ".viol_cnt"}, 32'(viol_cnt), LOG_EN ? 32'(exp_cnt) : 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; viol_req = 1'b0; viol_cause = 2'd0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       rst;
    logic       req;
    logic [1:0] cause;
    int         n;
    logic       puc;
    logic       lock;
    logic       bsy;
    logic [1:0] lc;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    //             rst   req   cause  n   puc   lock  busy  lc     cnt
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 2,  1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 1,  1'b1, 1'b0, 1'b1, 2'd1, 8'd1};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 2,  1'b1, 1'b0, 1'b1, 2'd1, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 13, 1'b1, 1'b0, 1'b1, 2'd1, 8'd1};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 1,  1'b0, 1'b0, 1'b1, 2'd1, 8'd1};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 3,  1'b0, 1'b0, 1'b0, 2'd1, 8'd1};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 1,  1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 1,  1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 2'd3, 1,  1'b1, 1'b0, 1'b1, 2'd3, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 4,  1'b1, 1'b0, 1'b1, 2'd3, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 1,  1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 2,  1'b0, 1'b0, 1'b0, 2'd0, 8'd0};

    rst = 1'b1; viol_req = 1'b0; viol_cause = 2'd0;

    // Reset state, a 3-cycle request (16-cycle pulse then IDLE), rst over
    // viol_req in the same cycle, and rst during HOLD cycle 5.
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; viol_req = vecs[i].req; viol_cause = vecs[i].cause;
      for (int k = 0; k < vecs[i].n; k++) begin
        tick();
        check($sformatf("vec%0d[%0d].puc_rst", i, k), 32'(puc_rst), 32'(vecs[i].puc));
        check($sformatf("vec%0d[%0d].lockout", i, k), 32'(lockout), 32'(vecs[i].lock));
        check($sformatf("vec%0d[%0d].busy", i, k), 32'(busy), 32'(vecs[i].bsy));
        check($sformatf("vec%0d[%0d].last_cause", i, k), 32'(last_cause),
              LOG_EN ? 32'(vecs[i].lc) : 32'd0);
        check($sformatf("vec%0d[%0d].viol_cnt", i, k), 32'(viol_cnt),
              LOG_EN ? 32'(vecs[i].cnt) : 32'd0);
      end
    end
    model_reset();

    // Continuous request: three pulses with 8-cycle gaps, then lockout.
    // The cause changes during the retries and must not be captured.
    viol_req = 1'b1; viol_cause = 2'd0; model_start(2'd0);
    expect_span(16, 1'b1, 1'b0, 1'b1, "s2_pulse1");
    viol_cause = 2'd2;
    expect_span(8,  1'b0, 1'b0, 1'b1, "s2_gap1");
    expect_span(16, 1'b1, 1'b0, 1'b1, "s2_pulse2");
    expect_span(8,  1'b0, 1'b0, 1'b1, "s2_gap2");
    expect_span(16, 1'b1, 1'b0, 1'b1, "s2_pulse3");
    expect_span(8,  1'b0, 1'b0, 1'b1, "s2_gap3");
    expect_span(1,  1'b1, 1'b1, 1'b1, "s2_lock");
    viol_req = 1'b0; viol_cause = 2'd3;
    expect_span(5,  1'b1, 1'b1, 1'b1, "s2_lock_hold");
    check_log("s2_log");
    rst = 1'b1; viol_req = 1'b1;
    expect_span(1,  1'b0, 1'b0, 1'b0, "s2_rst_lockout");
    rst = 1'b0; viol_req = 1'b0; model_reset();
    expect_span(1,  1'b0, 1'b0, 1'b0, "s2_idle");
    check_log("s2_log_rst");

    // Request drops in the second GUARD: back to IDLE, and a new violation
    // gets the full three pulses again.
    viol_req = 1'b1; viol_cause = 2'd1; model_start(2'd1);
    expect_span(16, 1'b1, 1'b0, 1'b1, "s3_pulse1");
    expect_span(8,  1'b0, 1'b0, 1'b1, "s3_gap1");
    expect_span(16, 1'b1, 1'b0, 1'b1, "s3_pulse2");
    expect_span(3,  1'b0, 1'b0, 1'b1, "s3_guard2");
    viol_req = 1'b0;
    expect_span(1,  1'b0, 1'b0, 1'b0, "s3_idle");
    check_log("s3_log1");
    viol_req = 1'b1; viol_cause = 2'd3; model_start(2'd3);
    for (int p = 0; p < 3; p++) begin
      expect_span(16, 1'b1, 1'b0, 1'b1, $sformatf("s3_re_pulse%0d", p));
      expect_span(8,  1'b0, 1'b0, 1'b1, $sformatf("s3_re_gap%0d", p));
    end
    expect_span(1,  1'b1, 1'b1, 1'b1, "s3_lock");
    check_log("s3_log2");
    do_reset();

    // 300 single-cycle violations with cause 2: the log saturates at 255.
    for (int i = 0; i < 300; i++) begin
      viol_req = 1'b1; viol_cause = 2'd2; model_start(2'd2);
      tick();
      viol_req = 1'b0; viol_cause = 2'd1;
      repeat (17) tick();
      if (i == 99) check_log("s4_log100");
    end
    expect_span(1, 1'b0, 1'b0, 1'b0, "s4_idle");
    check_log("s4_log_sat");
    check("s4_model_cnt", 32'(exp_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
